// File: rtl/multi_deco.sv
// Multicycle main decoder for the rv32i control unit.
// A Moore FSM steps each instruction through 3-5 cycles and drives the
// enables of a shared-ALU / shared-memory datapath. It also traps illegal
// opcodes and keeps a count of retired instructions.
module multi_deco #(
  parameter logic EN_ITYPE        = 1'b1,
  parameter logic EN_JAL          = 1'b1,
  parameter logic TRAP_ON_ILLEGAL = 1'b1,
  parameter int   CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             zero,
  output logic             pcWrite,
  output logic             adrSrc,
  output logic             irWrite,
  output logic             memWrite,
  output logic             regWrite,
  output logic [1:0]       resultSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       inmSrc,
  output logic             illegal,
  output logic             instrDone,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_RTYPE = 7'd51;
  localparam logic [6:0] OP_ITYPE = 7'd19;
  localparam logic [6:0] OP_BEQ   = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ERROR    = 4'd11
  } stateT;

  // Per-state control word; held in a register so the outputs are glitch-free.
  typedef struct packed {
    logic       adrSrc;
    logic       irWrite;
    logic       memWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       pcUpdate;
    logic       branch;
    logic       illegal;
    logic       instrDone;
  } ctrlT;

  // Where an unsupported opcode goes from DECODE: a sticky trap or a quiet skip.
  localparam stateT ILLEGAL_TARGET = TRAP_ON_ILLEGAL ? ERROR : FETCH;

  stateT            stateReg;
  stateT            stateNext;
  ctrlT             ctrlReg;
  logic [CNT_W-1:0] instretReg;
  logic [1:0]       inmSrcRaw;

  // Moore output table: the control word that belongs to each state.
  function automatic ctrlT ctrlOf(input stateT s);
    ctrlT c;
    c = '0;
    case (s)
      FETCH: begin
        c.irWrite   = 1'b1;
        c.aluSrcB   = 2'b10;
        c.resultSrc = 2'b10;
        c.pcUpdate  = 1'b1;
      end
      DECODE: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b01;
      end
      MEMADR: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
      end
      EXECI: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
        c.aluOp   = 2'b10;
      end
      MEMREAD: begin
        c.adrSrc = 1'b1;
      end
      MEMWB: begin
        c.resultSrc = 2'b01;
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      MEMWRITE: begin
        c.adrSrc    = 1'b1;
        c.memWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      EXECR: begin
        c.aluSrcA = 2'b10;
        c.aluOp   = 2'b10;
      end
      ALUWB: begin
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      BEQ: begin
        c.aluSrcA   = 2'b10;
        c.aluOp     = 2'b01;
        c.branch    = 1'b1;
        c.instrDone = 1'b1;
      end
      JAL: begin
        c.aluSrcA  = 2'b01;
        c.aluSrcB  = 2'b10;
        c.pcUpdate = 1'b1;
      end
      ERROR: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state sequencing; op is only consulted in DECODE and MEMADR.
  always_comb begin
    stateNext = FETCH;
    case (stateReg)
      FETCH:  stateNext = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: stateNext = MEMADR;
          OP_RTYPE:          stateNext = EXECR;
          OP_ITYPE:          stateNext = EN_ITYPE ? EXECI : ILLEGAL_TARGET;
          OP_BEQ:            stateNext = BEQ;
          OP_JAL:            stateNext = EN_JAL ? JAL : ILLEGAL_TARGET;
          default:           stateNext = ILLEGAL_TARGET;
        endcase
      end
      MEMADR:   stateNext = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  stateNext = MEMWB;
      MEMWB:    stateNext = FETCH;
      MEMWRITE: stateNext = FETCH;
      EXECR:    stateNext = ALUWB;
      EXECI:    stateNext = ALUWB;
      JAL:      stateNext = ALUWB;
      ALUWB:    stateNext = FETCH;
      BEQ:      stateNext = FETCH;
      ERROR:    stateNext = ERROR;
      default:  stateNext = FETCH;
    endcase
  end

  // State, registered control word and retire counter; the counter bumps as
  // the FSM leaves a retiring state, and reset always wins over that bump.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= FETCH;
      ctrlReg    <= ctrlOf(FETCH);
      instretReg <= '0;
    end else begin
      stateReg <= stateNext;
      ctrlReg  <= ctrlOf(stateNext);
      if (ctrlReg.instrDone) begin
        instretReg <= instretReg + CNT_W'(1);
      end
    end
  end

  // Immediate format follows op directly in every state.
  always_comb begin
    inmSrcRaw = 2'b00;
    case (op)
      OP_STORE: inmSrcRaw = 2'b01;
      OP_BEQ:   inmSrcRaw = 2'b10;
      OP_JAL:   inmSrcRaw = 2'b11;
      default:  inmSrcRaw = 2'b00;
    endcase
  end

  // Every output is held at zero while reset is high.
  assign pcWrite   = ~reset & (ctrlReg.pcUpdate | (ctrlReg.branch & zero));
  assign adrSrc    = ~reset & ctrlReg.adrSrc;
  assign irWrite   = ~reset & ctrlReg.irWrite;
  assign memWrite  = ~reset & ctrlReg.memWrite;
  assign regWrite  = ~reset & ctrlReg.regWrite;
  assign illegal   = ~reset & ctrlReg.illegal;
  assign instrDone = ~reset & ctrlReg.instrDone;
  assign resultSrc = reset ? 2'b00 : ctrlReg.resultSrc;
  assign aluSrcA   = reset ? 2'b00 : ctrlReg.aluSrcA;
  assign aluSrcB   = reset ? 2'b00 : ctrlReg.aluSrcB;
  assign aluOp     = reset ? 2'b00 : ctrlReg.aluOp;
  assign inmSrc    = reset ? 2'b00 : inmSrcRaw;
  assign instret   = reset ? '0 : instretReg;
  assign state     = reset ? 4'd0 : stateReg;

endmodule
